// File: rtl/rv32i_exec_core_pkg.sv
// Shared types for the RV32I execute core.
// Holds the ALU mode and destination-source enums, the per-instruction control struct,
// the major opcode constants and a helper that maps an arithmetic funct3 to an ALU mode.
package rv32i_exec_core_pkg;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd,
    AluSge,
    AluSgeu,
    AluPassB
  } alu_mode_t;

  typedef enum logic [1:0] {
    DestNone   = 2'd0,
    DestAlu    = 2'd1,
    DestBus    = 2'd2,
    DestNextPc = 2'd3
  } dest_reg_from_t;

  typedef struct packed {
    logic           alu_in_a;       // 0 = rs1, 1 = pc
    logic           alu_in_b;       // 0 = rs2, 1 = imm
    dest_reg_from_t dest_reg_from;
    logic           pc_src;         // PC loads alu_out in write-back
    logic           branching;
    logic           dbus_re;
    logic           dbus_we;
  } ins_ctrl_signals_t;

  localparam logic [6:0] OpcodeLui    = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc  = 7'b0010111;
  localparam logic [6:0] OpcodeJal    = 7'b1101111;
  localparam logic [6:0] OpcodeJalr   = 7'b1100111;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeFence  = 7'b0001111;
  localparam logic [6:0] OpcodeSystem = 7'b1110011;

  // Arithmetic funct3 to ALU mode. `sub` only matters for funct3 000, `sra` for 101.
  function automatic alu_mode_t arith_mode(input logic [2:0] f3, input logic sub,
                                           input logic sra);
    alu_mode_t mode;
    unique case (f3)
      3'b000:  mode = sub ? AluSub : AluAdd;
      3'b001:  mode = AluSll;
      3'b010:  mode = AluSlt;
      3'b011:  mode = AluSltu;
      3'b100:  mode = AluXor;
      3'b101:  mode = sra ? AluSra : AluSrl;
      3'b110:  mode = AluOr;
      default: mode = AluAnd;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/rv32i_exec_core_alu.sv
// Purely combinational 32-bit ALU for the RV32I execute core.
// Ports: a, b (operands), mode (operation select), result.
// Shift amount is b[4:0]; compare modes return 0 or 1.
module rv32i_exec_core_alu
  import rv32i_exec_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_mode_t   mode,
  output logic [31:0] result
);

  logic        lt_s;
  logic        lt_u;
  logic [4:0]  shamt;

  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    unique case (mode)
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluSll:   result = a << shamt;
      AluSlt:   result = {31'b0, lt_s};
      AluSltu:  result = {31'b0, lt_u};
      AluXor:   result = a ^ b;
      AluSrl:   result = a >> shamt;
      AluSra:   result = $unsigned($signed(a) >>> shamt);
      AluOr:    result = a | b;
      AluAnd:   result = a & b;
      AluSge:   result = {31'b0, ~lt_s};
      AluSgeu:  result = {31'b0, ~lt_u};
      AluPassB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_exec_core.sv
// RV32I instruction decoder, sequencing control unit and ALU.
// Inputs : clk, rst (async, active-high), ir, stall, rs1_data, rs2_data, pc.
// Outputs: register selects and f3/f7 fields, sign-extended imm, len, operand and destination
//          mux selects, pc_src_alu, branching/branch_taken, data bus strobes, sequencing strobes
//          (load_ir, en_iaddr, en_pc_counter, write_back_stage), alu_out and illegal.
// Sequence: FETCH -> EXECUTE -> WRITEBACK -> FETCH; stall freezes FETCH and EXECUTE.
module rv32i_exec_core
  import rv32i_exec_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        stall,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] pc,
  output logic [4:0]  rd_sel,
  output logic [4:0]  rs1_sel,
  output logic [4:0]  rs2_sel,
  output logic [2:0]  f3,
  output logic [6:0]  f7,
  output logic [31:0] imm,
  output logic [31:0] len,
  output logic        alu_in_a,
  output logic        alu_in_b,
  output logic [1:0]  dest_reg_from,
  output logic        pc_src_alu,
  output logic        branching,
  output logic        branch_taken,
  output logic        dbus_re,
  output logic        dbus_we,
  output logic        load_ir,
  output logic        en_iaddr,
  output logic        en_pc_counter,
  output logic        write_back_stage,
  output logic [31:0] alu_out,
  output logic        illegal
);

  localparam logic [1:0] StFetch     = 2'd0;
  localparam logic [1:0] StExecute   = 2'd1;
  localparam logic [1:0] StWriteback = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [6:0]        opcode;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;
  ins_ctrl_signals_t ctrl;
  alu_mode_t         mode;
  logic              is_jalr;
  logic [31:0]       op_a, op_b, alu_res;
  logic              in_fetch, in_exec, in_wb, ctrl_active;

  // Field extraction.
  assign opcode  = ir[6:0];
  assign rd_sel  = ir[11:7];
  assign rs1_sel = ir[19:15];
  assign rs2_sel = ir[24:20];
  assign f3      = ir[14:12];
  assign f7      = ir[31:25];
  assign len     = (ir[1:0] == 2'b11) ? 32'd4 : 32'd2;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  // Opcode decode. Compressed encodings never match a 32-bit opcode and land in default.
  always_comb begin
    ctrl               = '0;
    ctrl.dest_reg_from = DestNone;
    mode               = AluAdd;
    imm                = '0;
    is_jalr            = 1'b0;
    illegal            = 1'b0;
    unique case (opcode)
      OpcodeLui: begin
        imm                = imm_u;
        ctrl.alu_in_b      = 1'b1;
        ctrl.dest_reg_from = DestAlu;
        mode               = AluPassB;
      end
      OpcodeAuipc: begin
        imm                = imm_u;
        ctrl.alu_in_a      = 1'b1;
        ctrl.alu_in_b      = 1'b1;
        ctrl.dest_reg_from = DestAlu;
      end
      OpcodeJal: begin
        imm                = imm_j;
        ctrl.alu_in_a      = 1'b1;
        ctrl.alu_in_b      = 1'b1;
        ctrl.dest_reg_from = DestNextPc;
        ctrl.pc_src        = 1'b1;
      end
      OpcodeJalr: begin
        imm                = imm_i;
        ctrl.alu_in_b      = 1'b1;
        ctrl.dest_reg_from = DestNextPc;
        ctrl.pc_src        = 1'b1;
        is_jalr            = 1'b1;
      end
      OpcodeBranch: begin
        imm            = imm_b;
        ctrl.branching = 1'b1;
        // Equality tests use XOR (zero means equal); ordered tests compute ">=" and
        // branch_taken inverts it for the less-than forms via f3[0].
        unique case (ir[14:13])
          2'b10:   mode = AluSge;
          2'b11:   mode = AluSgeu;
          default: mode = AluXor;
        endcase
      end
      OpcodeLoad: begin
        imm                = imm_i;
        ctrl.alu_in_b      = 1'b1;
        ctrl.dest_reg_from = DestBus;
        ctrl.dbus_re       = 1'b1;
      end
      OpcodeStore: begin
        imm           = imm_s;
        ctrl.alu_in_b = 1'b1;
        ctrl.dbus_we  = 1'b1;
      end
      OpcodeOpImm: begin
        imm                = imm_i;
        ctrl.alu_in_b      = 1'b1;
        ctrl.dest_reg_from = DestAlu;
        mode               = arith_mode(ir[14:12], 1'b0, ir[30]);
      end
      OpcodeOp: begin
        ctrl.dest_reg_from = DestAlu;
        mode               = arith_mode(ir[14:12], ir[30], ir[30]);
      end
      OpcodeFence, OpcodeSystem: begin
        imm = imm_i;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // ALU and operand muxes.
  assign op_a = ctrl.alu_in_a ? pc : rs1_data;
  assign op_b = ctrl.alu_in_b ? imm : rs2_data;

  rv32i_exec_core_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .mode   (mode),
    .result (alu_res)
  );

  assign alu_out  = is_jalr ? {alu_res[31:1], 1'b0} : alu_res;
  assign alu_in_a = ctrl.alu_in_a;
  assign alu_in_b = ctrl.alu_in_b;

  // Sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:     if (!stall) state_d = StExecute;
      StExecute:   if (!stall) state_d = StWriteback;
      StWriteback: state_d = StFetch;
      default:     state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Gating with rst keeps every strobe low for the whole reset, including the cycle in which
  // reset is asserted mid-instruction.
  assign in_fetch    = !rst && (state_q == StFetch);
  assign in_exec     = !rst && (state_q == StExecute);
  assign in_wb       = !rst && (state_q == StWriteback);
  assign ctrl_active = in_exec || in_wb;

  assign load_ir          = in_fetch;
  assign en_iaddr         = in_fetch;
  assign write_back_stage = in_wb;
  assign en_pc_counter    = in_wb;

  assign dest_reg_from = ctrl_active ? ctrl.dest_reg_from : DestNone;
  assign pc_src_alu    = ctrl_active && ctrl.pc_src;
  assign branching     = ctrl_active && ctrl.branching;
  assign branch_taken  = branching && ((alu_out != 32'd0) == ir[12]);
  assign dbus_re       = in_exec && ctrl.dbus_re;
  assign dbus_we       = in_exec && ctrl.dbus_we;

endmodule

// File: tb/tb_rv32i_exec_core.sv
// Self-checking bench for rv32i_exec_core: directed cases plus randomized instructions
// compared against an instruction-level reference model.
module tb_rv32i_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        stall;
  logic [31:0] rs1_data, rs2_data, pc;
  logic [4:0]  rd_sel, rs1_sel, rs2_sel;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm, len, alu_out;
  logic        alu_in_a, alu_in_b;
  logic [1:0]  dest_reg_from;
  logic        pc_src_alu, branching, branch_taken, dbus_re, dbus_we;
  logic        load_ir, en_iaddr, en_pc_counter, write_back_stage, illegal;

  rv32i_exec_core dut (
    .clk              (clk),
    .rst              (rst),
    .ir               (ir),
    .stall            (stall),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .pc               (pc),
    .rd_sel           (rd_sel),
    .rs1_sel          (rs1_sel),
    .rs2_sel          (rs2_sel),
    .f3               (f3),
    .f7               (f7),
    .imm              (imm),
    .len              (len),
    .alu_in_a         (alu_in_a),
    .alu_in_b         (alu_in_b),
    .dest_reg_from    (dest_reg_from),
    .pc_src_alu       (pc_src_alu),
    .branching        (branching),
    .branch_taken     (branch_taken),
    .dbus_re          (dbus_re),
    .dbus_we          (dbus_we),
    .load_ir          (load_ir),
    .en_iaddr         (en_iaddr),
    .en_pc_counter    (en_pc_counter),
    .write_back_stage (write_back_stage),
    .alu_out          (alu_out),
    .illegal          (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] alu;
    logic        a_sel, b_sel;
    logic [1:0]  dest;
    logic        pc_src, br, taken, re, we, ill;
    logic        chk_imm, chk_alu, chk_a, chk_b;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] arith(input logic [2:0] fn, input logic [31:0] x,
                                        input logic [31:0] y, input bit sub, input bit sra);
    case (fn)
      3'd0:    return sub ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return sra ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  // Instruction-level reference: what each RV32I instruction should present.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] p);
    exp_t        e;
    logic [31:0] ii, si, bi, ui, ji;
    ii = {{20{i[31]}}, i[31:20]};
    si = {{20{i[31]}}, i[31:25], i[11:7]};
    bi = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    ui = {i[31:12], 12'b0};
    ji = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '0;
    e.chk_imm = 1'b1; e.chk_alu = 1'b1; e.chk_a = 1'b1; e.chk_b = 1'b1;
    case (i[6:0])
      7'h37: begin e.imm = ui; e.b_sel = 1; e.alu = ui; e.dest = 2'd1; e.chk_a = 0; end
      7'h17: begin e.imm = ui; e.a_sel = 1; e.b_sel = 1; e.alu = p + ui; e.dest = 2'd1; end
      7'h6F: begin
        e.imm = ji; e.a_sel = 1; e.b_sel = 1; e.alu = p + ji; e.dest = 2'd3; e.pc_src = 1;
      end
      7'h67: begin
        e.imm = ii; e.b_sel = 1; e.alu = (r1 + ii) & ~32'd1; e.dest = 2'd3; e.pc_src = 1;
      end
      7'h63: begin
        e.imm = bi; e.br = 1;
        case (i[14:12])
          3'd0: begin e.taken = (r1 == r2); e.alu = r1 ^ r2; end
          3'd1: begin e.taken = (r1 != r2); e.alu = r1 ^ r2; end
          3'd4: begin e.taken = ($signed(r1) < $signed(r2));
                      e.alu = ($signed(r1) >= $signed(r2)) ? 32'd1 : 32'd0; end
          3'd5: begin e.taken = ($signed(r1) >= $signed(r2));
                      e.alu = ($signed(r1) >= $signed(r2)) ? 32'd1 : 32'd0; end
          3'd6: begin e.taken = (r1 < r2); e.alu = (r1 >= r2) ? 32'd1 : 32'd0; end
          3'd7: begin e.taken = (r1 >= r2); e.alu = (r1 >= r2) ? 32'd1 : 32'd0; end
          default: e.chk_alu = 0;
        endcase
      end
      7'h03: begin e.imm = ii; e.b_sel = 1; e.alu = r1 + ii; e.dest = 2'd2; e.re = 1; end
      7'h23: begin e.imm = si; e.b_sel = 1; e.alu = r1 + si; e.we = 1; end
      7'h13: begin
        e.imm = ii; e.b_sel = 1; e.dest = 2'd1; e.alu = arith(i[14:12], r1, ii, 0, i[30]);
      end
      7'h33: begin
        e.imm = 0; e.dest = 2'd1; e.alu = arith(i[14:12], r1, r2, i[30], i[30]);
      end
      7'h0F, 7'h73: begin e.chk_imm = 0; e.chk_alu = 0; e.chk_a = 0; e.chk_b = 0; end
      default: begin e.ill = 1; e.chk_alu = 0; e.chk_a = 0; e.chk_b = 0; end
    endcase
    return e;
  endfunction

  task automatic check_zero();
    check_eq("rst_load_ir", load_ir, 0);
    check_eq("rst_en_iaddr", en_iaddr, 0);
    check_eq("rst_wb_stage", write_back_stage, 0);
    check_eq("rst_en_pc_counter", en_pc_counter, 0);
    check_eq("rst_dest", dest_reg_from, 0);
    check_eq("rst_dbus_re", dbus_re, 0);
    check_eq("rst_dbus_we", dbus_we, 0);
    check_eq("rst_pc_src", pc_src_alu, 0);
    check_eq("rst_branching", branching, 0);
  endtask

  task automatic check_fetch();
    check_eq("fetch_load_ir", load_ir, 1);
    check_eq("fetch_en_iaddr", en_iaddr, 1);
    check_eq("fetch_wb_stage", write_back_stage, 0);
    check_eq("fetch_en_pc", en_pc_counter, 0);
    check_eq("fetch_dest", dest_reg_from, 0);
    check_eq("fetch_ctrl", {pc_src_alu, branching, branch_taken, dbus_re, dbus_we}, 0);
  endtask

  // Decoded view in EXECUTE (exec=1) or WRITEBACK (exec=0).
  task automatic check_decoded(input bit exec);
    string ph;
    ph = exec ? "ex_" : "wb_";
    check_eq({ph, "rd_sel"}, rd_sel, ir[11:7]);
    check_eq({ph, "rs1_sel"}, rs1_sel, ir[19:15]);
    check_eq({ph, "rs2_sel"}, rs2_sel, ir[24:20]);
    check_eq({ph, "f3f7"}, {f7, f3}, {ir[31:25], ir[14:12]});
    check_eq({ph, "len"}, len, (ir[1:0] == 2'b11) ? 32'd4 : 32'd2);
    check_eq({ph, "illegal"}, illegal, cur.ill);
    if (cur.chk_imm) check_eq({ph, "imm"}, imm, cur.imm);
    if (cur.chk_a) check_eq({ph, "alu_in_a"}, alu_in_a, cur.a_sel);
    if (cur.chk_b) check_eq({ph, "alu_in_b"}, alu_in_b, cur.b_sel);
    if (cur.chk_alu) check_eq({ph, "alu_out"}, alu_out, cur.alu);
    check_eq({ph, "dest"}, dest_reg_from, cur.dest);
    check_eq({ph, "pc_src"}, pc_src_alu, cur.pc_src);
    check_eq({ph, "branching"}, branching, cur.br);
    check_eq({ph, "branch_taken"}, branch_taken, cur.taken);
    check_eq({ph, "dbus_re"}, dbus_re, exec && cur.re);
    check_eq({ph, "dbus_we"}, dbus_we, exec && cur.we);
    check_eq({ph, "load_ir"}, {load_ir, en_iaddr}, 0);
    check_eq({ph, "wb_stage"}, write_back_stage, !exec);
    check_eq({ph, "en_pc"}, en_pc_counter, !exec);
  endtask

  // Presents an instruction in FETCH, holds it for fstall cycles, then enters EXECUTE.
  task automatic go_execute(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] p, input int fstall);
    ir = i; rs1_data = r1; rs2_data = r2; pc = p;
    cur = model(i, r1, r2, p);
    stall = (fstall > 0);
    #1;
    check_fetch();
    for (int k = 0; k < fstall; k++) begin
      tick();
      check_fetch();
    end
    stall = 1'b0;
    tick();
    check_decoded(1'b1);
  endtask

  // Holds EXECUTE for xstall extra cycles, checks WRITEBACK, returns to FETCH.
  task automatic finish_instr(input int xstall);
    stall = (xstall > 0);
    for (int k = 0; k < xstall; k++) begin
      tick();
      check_decoded(1'b1);
      if (k == xstall - 1) stall = 1'b0;
    end
    stall = 1'b0;
    tick();
    check_decoded(1'b0);
    tick();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [2:0]  b;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'h37;
      1:  r[6:0] = 7'h17;
      2:  r[6:0] = 7'h6F;
      3:  begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
      4:  begin
        r[6:0] = 7'h63;
        b = 3'($urandom_range(0, 5));
        if (b >= 3'd2) b = b + 3'd2;
        r[14:12] = b;
      end
      5:  r[6:0] = 7'h03;
      6:  r[6:0] = 7'h23;
      7:  begin
        r[6:0] = 7'h13;
        if (r[14:12] == 3'd1) r[31:25] = 7'd0;
        if (r[14:12] == 3'd5) r[31:25] = {1'b0, r[30], 5'd0};
      end
      8:  begin
        r[6:0] = 7'h33;
        r[31:25] = (r[14:12] == 3'd0 || r[14:12] == 3'd5) ? {1'b0, r[30], 5'd0} : 7'd0;
      end
      9:  r[6:0] = ($urandom_range(0, 1) == 0) ? 7'h0F : 7'h73;
      10: r[1:0] = 2'($urandom_range(0, 2));
      default: r[6:0] = 7'h0B;
    endcase
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r1, r2, ri;
    rst = 1'b1; stall = 1'b0; ir = '0; rs1_data = '0; rs2_data = '0; pc = '0;
    repeat (2) tick();
    check_zero();
    rst = 1'b0;
    #1;
    check_fetch();

    // ADDI x1, x0, 5
    go_execute(32'h00500093, 32'd0, 32'd0, 32'h100, 0);
    check_eq("addi_rd_sel", rd_sel, 5'd1);
    check_eq("addi_imm", imm, 32'd5);
    check_eq("addi_alu", alu_out, 32'd5);
    check_eq("addi_dest", dest_reg_from, 2'd1);
    tick();
    check_eq("addi_wb_next", write_back_stage, 1'b1);
    tick();
    check_eq("addi_back_fetch", load_ir, 1'b1);

    // SUB 3 - 5
    go_execute(32'h40208133, 32'd3, 32'd5, 32'h104, 1);
    check_eq("sub_alu", alu_out, 32'hFFFFFFFE);
    finish_instr(0);

    // BEQ taken / not taken
    go_execute(32'hFE208EE3, 32'd7, 32'd7, 32'h108, 0);
    check_eq("beq_imm", imm, 32'hFFFFFFFC);
    check_eq("beq_taken", branch_taken, 1'b1);
    finish_instr(0);
    go_execute(32'hFE208EE3, 32'd7, 32'd8, 32'h10C, 0);
    check_eq("beq_not_taken", branch_taken, 1'b0);
    finish_instr(0);

    // LW with 3 stall cycles in EXECUTE
    go_execute(32'h0000A103, 32'h200, 32'd0, 32'h110, 0);
    check_eq("lw_re_first", dbus_re, 1'b1);
    finish_instr(3);

    // LUI, SRAI 31
    go_execute(32'h12345037, 32'd0, 32'd0, 32'h114, 0);
    check_eq("lui_alu", alu_out, 32'h12345000);
    finish_instr(0);
    go_execute(32'h41F0D093, 32'h80000000, 32'd0, 32'h118, 0);
    check_eq("srai_alu", alu_out, 32'hFFFFFFFF);
    finish_instr(0);

    // Reset pulse between edges during EXECUTE: strobes drop at once, FETCH follows release.
    go_execute(32'h0000A103, 32'h40, 32'd0, 32'h11C, 0);
    rst = 1'b1;
    #1;
    check_zero();
    rst = 1'b0;
    #1;
    check_fetch();
    // Reset held across an edge.
    go_execute(32'h00112023, 32'h80, 32'h5, 32'h120, 0);
    rst = 1'b1;
    tick();
    check_zero();
    rst = 1'b0;
    #1;
    check_fetch();

    for (int n = 0; n < 300; n++) begin
      ri = gen_instr();
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      go_execute(ri, r1, r2, $urandom, int'($urandom_range(0, 2)));
      finish_instr(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
